// File: rtl/rs_alu.sv
// Reservation station for the ALU. Holds dispatched instructions until both operands
// are resolved, snoops the two CDBs, and issues one ready entry per cycle in index order.
module rs_alu #(
    parameter int ROB_BIT = 4,
    parameter int RS_SIZE = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               rob_clear_up,
    input  logic               inst_valid,
    input  logic [2:0]         inst_op,
    input  logic [6:0]         inst_op_type,
    input  logic               inst_op_addition,
    input  logic [ROB_BIT-1:0] inst_rob_entry,
    input  logic               inst_qi_valid,
    input  logic [ROB_BIT-1:0] inst_qi,
    input  logic [31:0]        inst_vi,
    input  logic               inst_qj_valid,
    input  logic [ROB_BIT-1:0] inst_qj,
    input  logic [31:0]        inst_vj,
    input  logic               cdb_alu_ready,
    input  logic [31:0]        cdb_alu_res,
    input  logic [ROB_BIT-1:0] cdb_alu_rob_entry,
    input  logic               cdb_lsb_ready,
    input  logic [31:0]        cdb_lsb_res,
    input  logic [ROB_BIT-1:0] cdb_lsb_rob_entry,
    output logic               full,
    output logic               alu_valid,
    output logic [31:0]        alu_vi,
    output logic [31:0]        alu_vj,
    output logic [2:0]         alu_op,
    output logic [6:0]         alu_op_type,
    output logic               alu_op_addition,
    output logic [ROB_BIT-1:0] alu_rob_entry
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] qi_valid;
    logic [RS_SIZE-1:0] qj_valid;
    logic [2:0]         op          [RS_SIZE];
    logic [6:0]         op_type     [RS_SIZE];
    logic               op_addition [RS_SIZE];
    logic [ROB_BIT-1:0] rob_entry   [RS_SIZE];
    logic [ROB_BIT-1:0] qi          [RS_SIZE];
    logic [ROB_BIT-1:0] qj          [RS_SIZE];
    logic [31:0]        vi          [RS_SIZE];
    logic [31:0]        vj          [RS_SIZE];

    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] iss_idx;
    logic             iss_found;
    logic             disp_qi_valid;
    logic             disp_qj_valid;
    logic [31:0]      disp_vi;
    logic [31:0]      disp_vj;

    // Handshake: inst_valid is taken at an edge only while full is low (otherwise dropped);
    // alu_valid is a one-cycle pulse per issued entry with no backpressure from the ALU.
    assign full = &busy;

    always_comb begin
        free_idx  = '0;
        iss_idx   = '0;
        iss_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
            if (busy[i] && !qi_valid[i] && !qj_valid[i]) begin
                iss_idx   = IDX_W'(i);
                iss_found = 1'b1;
            end
        end
    end

    // Operands whose producer broadcasts in the dispatch cycle are stored resolved.
    always_comb begin
        disp_qi_valid = inst_qi_valid;
        disp_vi       = inst_vi;
        disp_qj_valid = inst_qj_valid;
        disp_vj       = inst_vj;
        if (inst_qi_valid && cdb_alu_ready && inst_qi == cdb_alu_rob_entry) begin
            disp_qi_valid = 1'b0;
            disp_vi       = cdb_alu_res;
        end else if (inst_qi_valid && cdb_lsb_ready && inst_qi == cdb_lsb_rob_entry) begin
            disp_qi_valid = 1'b0;
            disp_vi       = cdb_lsb_res;
        end
        if (inst_qj_valid && cdb_alu_ready && inst_qj == cdb_alu_rob_entry) begin
            disp_qj_valid = 1'b0;
            disp_vj       = cdb_alu_res;
        end else if (inst_qj_valid && cdb_lsb_ready && inst_qj == cdb_lsb_rob_entry) begin
            disp_qj_valid = 1'b0;
            disp_vj       = cdb_lsb_res;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy            <= '0;
            qi_valid        <= '0;
            qj_valid        <= '0;
            alu_valid       <= 1'b0;
            alu_vi          <= '0;
            alu_vj          <= '0;
            alu_op          <= '0;
            alu_op_type     <= '0;
            alu_op_addition <= 1'b0;
            alu_rob_entry   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op[i]          <= '0;
                op_type[i]     <= '0;
                op_addition[i] <= 1'b0;
                rob_entry[i]   <= '0;
                qi[i]          <= '0;
                qj[i]          <= '0;
                vi[i]          <= '0;
                vj[i]          <= '0;
            end
        end else if (rdy_in) begin
            if (rob_clear_up) begin
                busy      <= '0;
                alu_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && qi_valid[i]) begin
                        if (cdb_alu_ready && qi[i] == cdb_alu_rob_entry) begin
                            vi[i]       <= cdb_alu_res;
                            qi_valid[i] <= 1'b0;
                        end else if (cdb_lsb_ready && qi[i] == cdb_lsb_rob_entry) begin
                            vi[i]       <= cdb_lsb_res;
                            qi_valid[i] <= 1'b0;
                        end
                    end
                    if (busy[i] && qj_valid[i]) begin
                        if (cdb_alu_ready && qj[i] == cdb_alu_rob_entry) begin
                            vj[i]       <= cdb_alu_res;
                            qj_valid[i] <= 1'b0;
                        end else if (cdb_lsb_ready && qj[i] == cdb_lsb_rob_entry) begin
                            vj[i]       <= cdb_lsb_res;
                            qj_valid[i] <= 1'b0;
                        end
                    end
                end

                if (iss_found) begin
                    alu_valid       <= 1'b1;
                    alu_vi          <= vi[iss_idx];
                    alu_vj          <= vj[iss_idx];
                    alu_op          <= op[iss_idx];
                    alu_op_type     <= op_type[iss_idx];
                    alu_op_addition <= op_addition[iss_idx];
                    alu_rob_entry   <= rob_entry[iss_idx];
                    busy[iss_idx]   <= 1'b0;
                end else begin
                    alu_valid <= 1'b0;
                end

                // free_idx is never the issuing entry, so these writes cannot collide.
                if (inst_valid && !full) begin
                    busy[free_idx]        <= 1'b1;
                    op[free_idx]          <= inst_op;
                    op_type[free_idx]     <= inst_op_type;
                    op_addition[free_idx] <= inst_op_addition;
                    rob_entry[free_idx]   <= inst_rob_entry;
                    qi_valid[free_idx]    <= disp_qi_valid;
                    qi[free_idx]          <= inst_qi;
                    vi[free_idx]          <= disp_vi;
                    qj_valid[free_idx]    <= disp_qj_valid;
                    qj[free_idx]          <= inst_qj;
                    vj[free_idx]          <= disp_vj;
                end
            end
        end
    end
endmodule

// File: doc/rs_alu.md
RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 The block SHALL have parameter ROB_BIT, default 4, the width of a ROB entry tag.
REQ-002 The block SHALL have parameter RS_SIZE, default 8, the number of reservation-station entries (power of two).
REQ-003 The block SHALL have port clk_in  input  1  system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_in  input  1  reset; asynchronous and active-high.
REQ-005 The block SHALL have port rdy_in  input  1  ready; when low, all state and outputs hold.
REQ-006 The block SHALL have port rob_clear_up  input  1  misprediction flush request.
REQ-007 The block SHALL have port inst_valid  input  1  dispatch request from the decoder.
REQ-008 The block SHALL have ports inst_op (input, 3 bits), inst_op_type (input, 7 bits) and inst_op_addition (input, 1 bit), giving the ALU opcode fields of the dispatched instruction.
REQ-009 The block SHALL have port inst_rob_entry  input  ROB_BIT  destination ROB tag.
REQ-010 The block SHALL have ports inst_qi_valid  input  1, inst_qi  input  ROB_BIT and inst_vi  input  32; these are operand i: the pending flag, the producer tag, and the value.
REQ-011 The block SHALL have ports inst_qj_valid  input  1, inst_qj  input  ROB_BIT and inst_vj  input  32; these are operand j (for I-type, vj carries the immediate and qj_valid is 0).
REQ-012 The block SHALL have ports cdb_alu_ready  input  1, cdb_alu_res  input  32 and cdb_alu_rob_entry  input  ROB_BIT; these are the ALU result broadcast.
REQ-013 The block SHALL have ports cdb_lsb_ready  input  1, cdb_lsb_res  input  32 and cdb_lsb_rob_entry  input  ROB_BIT; these are the load/store result broadcast.
REQ-014 The block SHALL have port full  output  1, asserted when all RS_SIZE entries are busy.
REQ-015 The block SHALL have registered outputs alu_valid (1 bit), alu_vi (32 bits), alu_vj (32 bits), alu_op (3 bits), alu_op_type (7 bits), alu_op_addition (1 bit) and alu_rob_entry (ROB_BIT bits), which drive the ALU issue port.

Function
REQ-016 Each entry SHALL hold: busy, op, op_type, op_addition, rob_entry, qi_valid, qi, vi, qj_valid, qj, vj.
REQ-017 full SHALL be a combinational function of the registered busy bits only.
REQ-018 When inst_valid=1 and full=0, the instruction SHALL be written into the lowest-index non-busy entry at the clock edge.
REQ-019 When inst_valid=1 and full=1, the instruction SHALL be dropped and no state SHALL change due to it.
REQ-020 Snoop: for every busy entry with qi_valid=1, if cdb_alu_ready=1 and qi=cdb_alu_rob_entry, the entry SHALL latch vi<=cdb_alu_res and clear qi_valid; the same rule SHALL apply for cdb_lsb, and for operand j.
REQ-021 If both CDBs match the same operand in the same cycle, the ALU bus SHALL take priority.
REQ-022 Dispatch bypass: a dispatched operand with a pending flag whose tag matches a CDB broadcast in the same cycle SHALL be stored already resolved, with the CDB value.
REQ-023 An entry SHALL be issue-eligible when busy=1, qi_valid=0 and qj_valid=0 in the registered state at the start of the cycle.
REQ-024 Each cycle, the lowest-index eligible entry SHALL be issued: its fields are copied to the alu_* outputs, alu_valid<=1, and busy is cleared at that edge.
REQ-025 If no entry is eligible, alu_valid SHALL be driven to 0 and the other alu_* outputs SHALL hold.
REQ-026 An entry SHALL issue no earlier than the cycle after it was dispatched; an operand resolved by CDB in cycle N SHALL make the entry eligible in cycle N+1.
REQ-027 Minimum dispatch-to-alu_valid latency SHALL be 2 edges, for an instruction whose operands are both ready at dispatch.
REQ-028 Issue (freeing entry k) and dispatch SHALL be allowed in the same edge; the dispatch slot SHALL be selected from pre-edge busy bits, so a freed entry is reusable only in the next cycle.
REQ-029 At most one dispatch and one issue SHALL occur per cycle.
REQ-030 rob_clear_up=1 with rdy_in=1 SHALL, at the edge: clear all busy bits and set alu_valid<=0; simultaneous dispatch and issue SHALL be discarded.
REQ-031 rdy_in=0 SHALL freeze all entries and outputs, including alu_valid, regardless of inst_valid, CDB and rob_clear_up.

Reset
REQ-032 While rst_in=1, asynchronously: all busy, qi_valid and qj_valid bits SHALL be 0; alu_valid=0; alu_vi, alu_vj and alu_rob_entry SHALL be 0; alu_op, alu_op_type and alu_op_addition SHALL be 0; full=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries; the first dispatch after deassertion SHALL go to entry 0.

Verification
REQ-034 Ready dispatch: dispatch ADD (op=000, op_type=0110011, vi=5, vj=7, rob=3, both q_valid=0) -> two edges later alu_valid=1, alu_vi=5, alu_vj=7, alu_rob_entry=3; one edge after that alu_valid=0.
REQ-035 CDB wakeup: dispatch with qi_valid=1, qi=2, vj=1; then cdb_alu_ready=1, rob=2, res=0x10 -> the next edge issues alu_vi=0x10; with cdb_lsb also matching in the same cycle (res=0x20), alu_vi=0x10.
REQ-036 Bypass: dispatch with qj_valid=1, qj=6 in the same cycle as cdb_lsb_ready=1, rob=6, res=0xFF -> the entry issues at the following edge with alu_vj=0xFF.
REQ-037 Full and ordering: dispatch 8 entries, all with pending tag 9 -> full=1; a 9th dispatch is dropped; broadcast tag 9 -> entries issue in index order 0..7 on consecutive edges; full drops after the first issue.
REQ-038 Flush and stall: 3 busy entries, rdy_in=0 with rob_clear_up=1 -> nothing changes; rdy_in=1 with rob_clear_up=1 -> all entries cleared, alu_valid=0, full=0.
REQ-039 Async reset: assert rst_in between clock edges while alu_valid=1 -> alu_valid falls immediately, without waiting for a clock edge.
